// File: rtl/fractal_sync_pkg.sv
// Shared types and defaults for the fractal_sync compute-unit driver.
package fractal_sync_pkg;

    localparam int unsigned DEF_N_CU           = 2;
    localparam int unsigned DEF_AGGR_WIDTH     = 6;
    localparam int unsigned DEF_ID_WIDTH       = 5;
    localparam int unsigned DEF_CNT_WIDTH      = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        REQ,
        WAIT,
        DONE,
        ERR
    } chan_state_e;

    typedef struct packed {
        logic                      sync;
        logic [DEF_AGGR_WIDTH-1:0] aggr;
        logic [DEF_ID_WIDTH-1:0]   id;
    } fsync_req_default_t;

    typedef struct packed {
        logic wake;
        logic error;
    } fsync_rsp_default_t;

endpackage

// File: rtl/fractal_sync_cu_driver_if.sv
// Request/response link between the compute-unit driver and the fractal_sync tree.
interface fractal_sync_cu_driver_if #(
    parameter int unsigned N_CU = fractal_sync_pkg::DEF_N_CU,
    parameter type fsync_req_t = fractal_sync_pkg::fsync_req_default_t,
    parameter type fsync_rsp_t = fractal_sync_pkg::fsync_rsp_default_t
) ();

    fsync_req_t req_o [N_CU];
    fsync_rsp_t rsp_i [N_CU];

    modport master (output req_o, input rsp_i);
    modport slave  (input req_o, output rsp_i);

endinterface

// File: rtl/fractal_sync_cu_chan.sv
// One compute-unit channel: compute countdown, barrier request, wait for wake.
// Define FSYNC_DRV_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles.
module fractal_sync_cu_chan
    import fractal_sync_pkg::*;
#(
    parameter int unsigned AGGR_WIDTH     = DEF_AGGR_WIDTH,
    parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  comp_cycles_i,
    input  logic [AGGR_WIDTH-1:0] aggr_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic                  wake_i,
    input  logic                  err_i,
    output logic                  sync_o,
    output logic [AGGR_WIDTH-1:0] aggr_o,
    output logic [ID_WIDTH-1:0]   id_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [CNT_WIDTH-1:0]  sync_cnt_o
);

    chan_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  sync_cnt_q, sync_cnt_d;
    logic [AGGR_WIDTH-1:0] aggr_q, aggr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  tmo_hit;

`ifdef FSYNC_DRV_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign sync_cnt_o = sync_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sync_cnt_d = sync_cnt_q;
        aggr_d     = aggr_q;
        id_d       = id_q;
`ifdef FSYNC_DRV_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        sync_o  = 1'b0;
        aggr_o  = '0;
        id_o    = '0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        error_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COMPUTE;
                    cnt_d   = comp_cycles_i;
                    aggr_d  = aggr_i;
                    id_d    = id_i;
                end
            end
            COMPUTE: begin
                busy_o = 1'b1;
                // Leave when the decrement would reach zero, so N yields N COMPUTE cycles (0 yields one).
                if (cnt_q <= CNT_WIDTH'(1)) state_d = REQ;
                else                        cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            REQ: begin
                busy_o  = 1'b1;
                sync_o  = 1'b1;
                aggr_o  = aggr_q;
                id_o    = id_q;
                state_d = WAIT;
`ifdef FSYNC_DRV_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT: begin
                busy_o = 1'b1;
                aggr_o = aggr_q;
                id_o   = id_q;
`ifdef FSYNC_DRV_TIMEOUT_EN
                tmo_d  = tmo_q + TMO_W'(1);
`endif
                if (err_i) begin
                    state_d = ERR;
                end else if (wake_i) begin
                    state_d    = DONE;
                    sync_cnt_d = sync_cnt_q + CNT_WIDTH'(1);
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                error_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sync_cnt_q <= '0;
            aggr_q     <= '0;
            id_q       <= '0;
`ifdef FSYNC_DRV_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_cnt_q <= sync_cnt_d;
            aggr_q     <= aggr_d;
            id_q       <= id_d;
`ifdef FSYNC_DRV_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: rtl/fractal_sync_cu_driver.sv
// N_CU independent compute-unit channels driving barrier requests into the fractal_sync tree.
// Optional WAIT timeout is enabled by defining FSYNC_DRV_TIMEOUT_EN.
module fractal_sync_cu_driver
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_CU           = DEF_N_CU,
    parameter int unsigned AGGR_WIDTH     = DEF_AGGR_WIDTH,
    parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter type fsync_req_t = fractal_sync_pkg::fsync_req_default_t,
    parameter type fsync_rsp_t = fractal_sync_pkg::fsync_rsp_default_t
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_CU-1:0]                      start_i,
    input  logic [N_CU-1:0][CNT_WIDTH-1:0]       comp_cycles_i,
    input  logic [N_CU-1:0][AGGR_WIDTH-1:0]      aggr_i,
    input  logic [N_CU-1:0][ID_WIDTH-1:0]        id_i,
    fractal_sync_cu_driver_if.master             tree,
    output logic [N_CU-1:0]                      busy_o,
    output logic [N_CU-1:0]                      done_o,
    output logic [N_CU-1:0]                      error_o,
    output logic [N_CU-1:0][CNT_WIDTH-1:0]       sync_cnt_o
);

    for (genvar g = 0; g < N_CU; g++) begin : gen_chan
        logic                  sync;
        logic [AGGR_WIDTH-1:0] aggr;
        logic [ID_WIDTH-1:0]   id;
        fsync_req_t            req_s;
        fsync_rsp_t            rsp_s;

        assign rsp_s = tree.rsp_i[g];

        fractal_sync_cu_chan #(
            .AGGR_WIDTH     (AGGR_WIDTH),
            .ID_WIDTH       (ID_WIDTH),
            .CNT_WIDTH      (CNT_WIDTH),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_chan (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .start_i       (start_i[g]),
            .comp_cycles_i (comp_cycles_i[g]),
            .aggr_i        (aggr_i[g]),
            .id_i          (id_i[g]),
            .wake_i        (rsp_s.wake),
            .err_i         (rsp_s.error),
            .sync_o        (sync),
            .aggr_o        (aggr),
            .id_o          (id),
            .busy_o        (busy_o[g]),
            .done_o        (done_o[g]),
            .error_o       (error_o[g]),
            .sync_cnt_o    (sync_cnt_o[g])
        );

        always_comb begin
            req_s      = '0;
            req_s.sync = sync;
            req_s.aggr = aggr;
            req_s.id   = id;
        end

        assign tree.req_o[g] = req_s;
    end

endmodule

// File: tb/tb_fractal_sync_cu_driver.sv
// Scoreboard bench: stimulus queues expected sync/done/error events, a negedge monitor checks them.
module tb_fractal_sync_cu_driver;
    import fractal_sync_pkg::*;

    localparam int K_SYNC = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int kind;
        int aggr;
        int id;
        int cnt;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  exq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       start_a = '0;
    logic [1:0][15:0] comp_a  = '0;
    logic [1:0][5:0]  aggr_a  = '0;
    logic [1:0][4:0]  id_a    = '0;
    logic [1:0]       busy_a, done_a, err_a;
    logic [1:0][15:0] cnt_a;

    logic [0:0]       start_b = '0;
    logic [0:0][1:0]  comp_b  = '0;
    logic [0:0][5:0]  aggr_b  = '0;
    logic [0:0][4:0]  id_b    = '0;
    logic [0:0]       busy_b, done_b, err_b;
    logic [0:0][1:0]  cnt_b;

    fractal_sync_cu_driver_if #(.N_CU(2)) tree_a ();
    fractal_sync_cu_driver_if #(.N_CU(1)) tree_b ();

    fractal_sync_cu_driver #(.N_CU(2), .TIMEOUT_CYCLES(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .comp_cycles_i(comp_a),
        .aggr_i(aggr_a), .id_i(id_a), .tree(tree_a), .busy_o(busy_a),
        .done_o(done_a), .error_o(err_a), .sync_cnt_o(cnt_a)
    );

    fractal_sync_cu_driver #(.N_CU(1), .CNT_WIDTH(2), .TIMEOUT_CYCLES(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .comp_cycles_i(comp_b),
        .aggr_i(aggr_b), .id_i(id_b), .tree(tree_b), .busy_o(busy_b),
        .done_o(done_b), .error_o(err_b), .sync_cnt_o(cnt_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int kind, input int aggr, input int id,
                        input int cnt, input int at_cyc);
        ev_t e;
        e.kind = kind; e.aggr = aggr; e.id = id; e.cnt = cnt; e.cyc = at_cyc;
        exq[ch].push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic set_rsp(input int ch, input logic wake, input logic error);
        if (ch == 0) begin
            tree_a.rsp_i[0].wake = wake; tree_a.rsp_i[0].error = error;
        end else if (ch == 1) begin
            tree_a.rsp_i[1].wake = wake; tree_a.rsp_i[1].error = error;
        end else begin
            tree_b.rsp_i[0].wake = wake; tree_b.rsp_i[0].error = error;
        end
    endtask

    always @(negedge clk) begin : monitor
        int o_kind [3];
        int o_aggr [3];
        int o_id [3];
        int o_cnt [3];
        ev_t e;
        if (rst_n) begin
            o_kind[0] = tree_a.req_o[0].sync ? K_SYNC : done_a[0] ? K_DONE : err_a[0] ? K_ERR : -1;
            o_kind[1] = tree_a.req_o[1].sync ? K_SYNC : done_a[1] ? K_DONE : err_a[1] ? K_ERR : -1;
            o_kind[2] = tree_b.req_o[0].sync ? K_SYNC : done_b[0] ? K_DONE : err_b[0] ? K_ERR : -1;
            o_aggr[0] = int'(tree_a.req_o[0].aggr); o_id[0] = int'(tree_a.req_o[0].id);
            o_aggr[1] = int'(tree_a.req_o[1].aggr); o_id[1] = int'(tree_a.req_o[1].id);
            o_aggr[2] = int'(tree_b.req_o[0].aggr); o_id[2] = int'(tree_b.req_o[0].id);
            o_cnt[0] = int'(cnt_a[0]); o_cnt[1] = int'(cnt_a[1]); o_cnt[2] = int'(cnt_b[0]);
            for (int ch = 0; ch < 3; ch++) begin
                if (o_kind[ch] >= 0) begin
                    if (exq[ch].size() == 0) begin
                        chk($sformatf("ch%0d_unexpected_event_kind", ch), o_kind[ch], 99);
                    end else begin
                        e = exq[ch].pop_front();
                        chk($sformatf("ch%0d_kind", ch), o_kind[ch], e.kind);
                        chk($sformatf("ch%0d_cycle", ch), cyc, e.cyc);
                        chk($sformatf("ch%0d_aggr", ch), o_aggr[ch], e.aggr);
                        chk($sformatf("ch%0d_id", ch), o_id[ch], e.id);
                        chk($sformatf("ch%0d_sync_cnt", ch), o_cnt[ch], e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int s;
        set_rsp(0, 0, 0); set_rsp(1, 0, 0); set_rsp(2, 0, 0);

        // reset state
        tick(3);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_error", err_a, 0);
        chk("rst_sync_cnt", cnt_a, 0);
        chk("rst_req0", tree_a.req_o[0], 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        tick(2);

        // single barrier: comp 10 -> sync 11 cycles after start
        s = cyc;
        start_a[0] = 1'b1; comp_a[0] = 16'd10; aggr_a[0] = 6'd1; id_a[0] = 5'd0;
        push(0, K_SYNC, 1, 0, 0, s + 11);
        tick(1);
        start_a[0] = 1'b0;
        at(s + 12);
        chk("wait_aggr_held", tree_a.req_o[0].aggr, 1);
        chk("wait_busy", busy_a[0], 1);
        set_rsp(0, 1, 0);
        push(0, K_DONE, 0, 0, 1, s + 13);
        tick(1);
        set_rsp(0, 0, 0);
        at(s + 16);

        // both channels, comp 10 and 50; wake on idle ch0 alongside ch1's wake
        s = cyc;
        start_a = 2'b11;
        comp_a[0] = 16'd10; aggr_a[0] = 6'd5;  id_a[0] = 5'd3;
        comp_a[1] = 16'd50; aggr_a[1] = 6'd42; id_a[1] = 5'd17;
        push(0, K_SYNC, 5, 3, 1, s + 11);
        push(1, K_SYNC, 42, 17, 0, s + 51);
        tick(1);
        start_a = 2'b00;
        at(s + 5);
        start_a[0] = 1'b1; comp_a[0] = 16'd0;
        tick(1);
        start_a[0] = 1'b0;
        at(s + 12);
        set_rsp(0, 1, 0);
        push(0, K_DONE, 0, 0, 2, s + 13);
        tick(1);
        set_rsp(0, 0, 0);
        at(s + 52);
        set_rsp(0, 1, 0); set_rsp(1, 1, 0);
        push(1, K_DONE, 0, 0, 1, s + 53);
        tick(1);
        set_rsp(0, 0, 0); set_rsp(1, 0, 0);
        at(s + 55);
        chk("dual_cnt0", cnt_a[0], 2);
        chk("dual_cnt1", cnt_a[1], 1);

        // wake in REQ ignored, wake+error in WAIT -> error, wake in IDLE ignored
        s = cyc;
        start_a[1] = 1'b1; comp_a[1] = 16'd0; aggr_a[1] = 6'd7; id_a[1] = 5'd9;
        push(1, K_SYNC, 7, 9, 1, s + 2);
        tick(1);
        start_a[1] = 1'b0;
        at(s + 2);
        set_rsp(1, 1, 0);
        tick(1);
        set_rsp(1, 1, 1);
        push(1, K_ERR, 0, 0, 1, s + 4);
        tick(1);
        set_rsp(1, 0, 0);
        at(s + 6);
        set_rsp(1, 1, 0);
        tick(1);
        set_rsp(1, 0, 0);
        at(s + 8);
        chk("idle_wake_cnt1", cnt_a[1], 1);
        chk("idle_wake_busy1", busy_a[1], 0);

        // no response in WAIT
        s = cyc;
        start_a[0] = 1'b1; comp_a[0] = 16'd2; aggr_a[0] = 6'd3; id_a[0] = 5'd4;
        push(0, K_SYNC, 3, 4, 2, s + 3);
        tick(1);
        start_a[0] = 1'b0;
`ifdef FSYNC_DRV_TIMEOUT_EN
        push(0, K_ERR, 0, 0, 2, s + 12);
        at(s + 14);
        chk("timeout_cnt0", cnt_a[0], 2);
`else
        at(s + 30);
        chk("no_timeout_busy0", busy_a[0], 1);
`endif

        // asynchronous reset while in WAIT
        s = cyc;
        start_a[1] = 1'b1; comp_a[1] = 16'd1; aggr_a[1] = 6'd1; id_a[1] = 5'd1;
        push(1, K_SYNC, 1, 1, 1, s + 2);
        tick(1);
        start_a[1] = 1'b0;
        at(s + 4);
        chk("pre_rst_busy1", busy_a[1], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_cnt", cnt_a, 0);
        chk("async_rst_req1", tree_a.req_o[1], 0);
        chk("async_rst_req0", tree_a.req_o[0], 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        set_rsp(0, 1, 0); set_rsp(1, 1, 0);
        tick(1);
        set_rsp(0, 0, 0); set_rsp(1, 0, 0);
        tick(2);
        chk("post_rst_busy", busy_a, 0);
        chk("post_rst_done", done_a, 0);
        chk("post_rst_cnt", cnt_a, 0);

        // CNT_WIDTH=2: five barriers wrap the counter to 1
        for (int i = 0; i < 5; i++) begin
            s = cyc;
            start_b[0] = 1'b1; comp_b[0] = 2'd0; aggr_b[0] = 6'(i); id_b[0] = 5'(i);
            push(2, K_SYNC, i, i, i % 4, s + 2);
            tick(1);
            start_b[0] = 1'b0;
            at(s + 3);
            set_rsp(2, 1, 0);
            push(2, K_DONE, 0, 0, (i + 1) % 4, s + 4);
            tick(1);
            set_rsp(2, 0, 0);
            at(s + 5);
        end
        chk("wrap_cnt_b", cnt_b[0], 1);

        tick(2);
        for (int ch = 0; ch < 3; ch++)
            chk($sformatf("ch%0d_missing_events", ch), exq[ch].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fractal_sync_cu_driver.md
FRACTAL_SYNC_CU_DRIVER -- requirements
Module: fractal_sync_cu_driver

Interface
REQ-001 SHALL have parameter N_CU, default 2, meaning the number of independent compute-unit channels (N_CU >= 1).
REQ-002 SHALL have parameter AGGR_WIDTH, default 6, meaning the aggregate field width.
REQ-003 SHALL have parameter ID_WIDTH, default 5, meaning the barrier-ID field width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning the compute-cycle counter width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the wait-for-wake limit in cycles.
REQ-006 SHALL have type parameters fsync_req_t (fields sync, aggr, id) and fsync_rsp_t (fields wake, error).
REQ-007 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-008 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port start_i, input, [N_CU], per-channel start pulse.
REQ-010 SHALL have port comp_cycles_i, input, [N_CU][CNT_WIDTH], per-channel compute duration.
REQ-011 SHALL have ports aggr_i and id_i, input, [N_CU][AGGR_WIDTH] and [N_CU][ID_WIDTH], per-channel barrier descriptor.
REQ-012 SHALL have port req_o, output, fsync_req_t[N_CU], sync requests toward the fractal_sync tree.
REQ-013 SHALL have port rsp_i, input, fsync_rsp_t[N_CU], responses from the tree.
REQ-014 SHALL have ports busy_o, done_o, error_o, output, [N_CU], per-channel status.
REQ-015 SHALL have port sync_cnt_o, output, [N_CU][CNT_WIDTH], per-channel count of completed barriers.

Function
REQ-016 SHALL implement per channel FSM states IDLE, COMPUTE, REQ, WAIT, DONE, ERR.
REQ-017 IDLE: start_i high SHALL latch comp_cycles_i, aggr_i, id_i and go to COMPUTE next cycle; start in any other state SHALL be ignored.
REQ-018 COMPUTE SHALL down-count the latched value, moving to REQ when the counter reaches 0; comp_cycles 0 SHALL go directly to REQ after one COMPUTE cycle.
REQ-019 REQ SHALL assert req_o.sync for exactly one cycle with the latched aggr and id, then go to WAIT.
REQ-020 req_o.aggr and req_o.id SHALL hold latched values in REQ and WAIT, and be 0 elsewhere; req_o.sync SHALL be 0 outside REQ.
REQ-021 WAIT: rsp_i.wake=1, error=0 SHALL go to DONE and increment sync_cnt_o (wrapping at 2^CNT_WIDTH to 0).
REQ-022 WAIT: rsp_i.error=1 SHALL go to ERR regardless of wake; sync_cnt_o unchanged.
REQ-023 rsp_i.wake or error outside WAIT SHALL be ignored (no state or counter change).
REQ-024 A wake arriving in the same cycle as REQ SHALL be ignored; only WAIT samples the response.
REQ-025 DONE and ERR SHALL each last one cycle, then return to IDLE; done_o/error_o SHALL be high exactly in those cycles.
REQ-026 busy_o SHALL be high in COMPUTE, REQ and WAIT.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-028 rst_ni low SHALL asynchronously force all channels to IDLE, all counters to 0, and all outputs to 0, including mid-WAIT.

Configuration
REQ-029 With FSYNC_DRV_TIMEOUT_EN defined, a WAIT lasting TIMEOUT_CYCLES cycles without wake/error SHALL go to ERR.
REQ-030 Without FSYNC_DRV_TIMEOUT_EN, WAIT SHALL persist indefinitely and no timeout counter SHALL be synthesised.

Structure
REQ-031 The state enum type and default constants SHALL live in fractal_sync_pkg.
REQ-032 One sub-module fractal_sync_cu_chan SHALL implement a single channel, instantiated N_CU times by generate.

Verification
REQ-033 Start ch0, comp_cycles=10, aggr=1, id=0 -> sync pulse 11 cycles after start (1 latch + 10 compute), one cycle wide, aggr=1, id=0.
REQ-034 Both channels started together, comp 10 and 50, single wake per channel in WAIT -> each done_o pulses once, sync_cnt_o=1 on both.
REQ-035 Wake+error together in WAIT -> error_o pulse, sync_cnt_o unchanged; wake in IDLE -> no change.
REQ-036 TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no response -> error_o exactly 8 cycles after WAIT entry; undefined -> busy_o stays 1.
REQ-037 rst_ni low during WAIT -> all outputs 0 immediately; later wake ignored; CNT_WIDTH=2, five barriers -> sync_cnt_o=1.
